// File: rtl/mem_responder_if.sv
// Request/response bundle between a hart memory port and its responder.
// The responder drives ready/valid/rdata/outstanding; the requester drives the rest.
interface mem_responder_if;
    logic        o_ready;
    logic [31:0] i_addr;
    logic        i_ren;
    logic        i_wen;
    logic [3:0]  i_mask;
    logic [31:0] i_wdata;
    logic        o_valid;
    logic [31:0] o_rdata;
    logic [3:0]  o_outstanding;

    modport slave (
        output o_ready,
        output o_valid,
        output o_rdata,
        output o_outstanding,
        input  i_addr,
        input  i_ren,
        input  i_wen,
        input  i_mask,
        input  i_wdata
    );

    modport master (
        input  o_ready,
        input  o_valid,
        input  o_rdata,
        input  o_outstanding,
        output i_addr,
        output i_ren,
        output i_wen,
        output i_mask,
        output i_wdata
    );
endinterface

// File: rtl/mem_responder.sv
// Memory responder for a hart imem/dmem port.
// Fixed read latency, minimum request spacing, byte-masked writes.
module mem_responder #(
    parameter int SIZE     = 1024,
    parameter int LATENCY  = 4,
    parameter int INTERVAL = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    mem_responder_if.slave  bus
);
    localparam int AW = $clog2(SIZE);
    localparam logic [3:0] HOLD_INIT =
        (INTERVAL > 1) ? 4'(INTERVAL - 2) : 4'd0;

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_lat
        $error("mem_responder: LATENCY must be 1..15");
    end
    if (INTERVAL < 1 || INTERVAL > 15) begin : g_bad_int
        $error("mem_responder: INTERVAL must be 1..15");
    end
    if (SIZE < 4 || (SIZE & (SIZE - 1)) != 0) begin : g_bad_size
        $error("mem_responder: SIZE must be a power of two >= 4");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READY,
        ST_HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    hold_q, hold_d;
    logic          req;
    logic          acc;
    logic          rd_acc;
    logic          wr_acc;
    logic [AW-1:0] idx;
    logic          unused_addr;

    logic [31:0]        mem [SIZE];
    logic [LATENCY-1:0] pv_q, pv_d;
    logic [31:0]        pd_q [LATENCY];
    logic [31:0]        pd_d [LATENCY];
    logic [3:0]         out_q, out_d;
    logic               valid;

    assign idx         = bus.i_addr[AW+1:2];
    assign unused_addr = ^{bus.i_addr[31:AW+2], bus.i_addr[1:0]};
    assign req         = bus.i_ren | bus.i_wen;
    assign acc         = (state_q == ST_READY) & req;
    assign rd_acc      = acc & bus.i_ren;
    assign wr_acc      = acc & bus.i_wen;
    assign valid       = pv_q[LATENCY-1];

    assign bus.o_ready       = (state_q == ST_READY);
    assign bus.o_valid       = valid;
    assign bus.o_rdata       = valid ? pd_q[LATENCY-1] : 32'd0;
    assign bus.o_outstanding = out_q;

    // Ready FSM: idle after reset, then ready; hold off after each acceptance.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            hold_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state: hold_q counts the remaining not-ready cycles minus one.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_READY;
            end
            ST_READY: begin
                if (acc && INTERVAL > 1) begin
                    state_d = ST_HOLD;
                    hold_d  = HOLD_INIT;
                end
            end
            ST_HOLD: begin
                if (hold_q == 4'd0) begin
                    state_d = ST_READY;
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                hold_d  = 4'd0;
            end
        endcase
    end

    // Byte-masked write into the backing store; contents survive reset.
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_acc && bus.i_mask[b]) begin
                mem[idx][8*b +: 8] <= bus.i_wdata[8*b +: 8];
            end
        end
    end

    // Response pipeline shift: stage 0 samples the pre-write word.
    always_comb begin
        pv_d    = '0;
        pv_d[0] = rd_acc;
        for (int i = 0; i < LATENCY; i++) begin
            pd_d[i] = 32'd0;
        end
        pd_d[0] = rd_acc ? mem[idx] : 32'd0;
        for (int i = 1; i < LATENCY; i++) begin
            pv_d[i] = pv_q[i-1];
            pd_d[i] = pd_q[i-1];
        end
    end

    // Pipeline registers; reset drops every in-flight read.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pv_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pd_q[i] <= 32'd0;
            end
        end else begin
            pv_q <= pv_d;
            for (int i = 0; i < LATENCY; i++) begin
                pd_q[i] <= pd_d[i];
            end
        end
    end

    // Outstanding reads: up on acceptance, down as each response leaves.
    always_comb begin
        out_d = out_q + {3'd0, rd_acc} - {3'd0, valid};
    end

    // Outstanding counter register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_q <= 4'd0;
        end else begin
            out_q <= out_d;
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed steps plus random traffic
// against a cycle-numbered reference model.
module tb_mem_responder;
    localparam int SIZE = 1024;
    localparam int LAT  = 4;
    localparam int IVL  = 2;

    logic clk;
    logic rst_n;

    mem_responder_if bus();

    mem_responder #(
        .SIZE(SIZE), .LATENCY(LAT), .INTERVAL(IVL)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    logic [31:0] mm [SIZE];
    rsp_t        q[$];
    int          edge_n;
    int          rel_edge;
    int          last_acc;
    bit          in_rst;
    bit          acc_flag;
    int          n_chk;
    int          n_fail;
    int          rsp_seen;
    int          peak_out;
    logic [31:0] last_rdata;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s edge=%0d observed=%h expected=%h",
                   tag, edge_n, obs, exp);
        end
    endtask

    function automatic bit can_accept(int e);
        return !in_rst && (e >= rel_edge + 1) && (e >= last_acc + IVL);
    endfunction

    task automatic step(input logic ren, input logic wen,
                        input logic [31:0] addr, input logic [3:0] mask,
                        input logic [31:0] wdata);
        int          wi;
        bit          ev;
        logic [31:0] ed;
        int          eo;
        bus.i_ren   = ren;
        bus.i_wen   = wen;
        bus.i_addr  = addr;
        bus.i_mask  = mask;
        bus.i_wdata = wdata;
        @(posedge clk);
        edge_n++;
        wi = int'(addr / 4) % SIZE;
        acc_flag = can_accept(edge_n) && (ren || wen);
        if (acc_flag) begin
            last_acc = edge_n;
            if (ren) q.push_back('{due: edge_n + LAT - 1, data: mm[wi]});
            if (wen) begin
                for (int b = 0; b < 4; b++) begin
                    if (mask[b]) mm[wi][8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end
        @(negedge clk);
        eo = q.size();
        ev = (q.size() > 0) && (q[0].due == edge_n);
        ed = ev ? q[0].data : 32'd0;
        if (ev) void'(q.pop_front());
        chk("ready", 32'(bus.o_ready), 32'(can_accept(edge_n + 1)));
        chk("valid", 32'(bus.o_valid), 32'(ev));
        chk("rdata", bus.o_rdata, ed);
        chk("outstanding", 32'(bus.o_outstanding), 32'(eo));
        if (bus.o_valid === 1'b1) begin
            rsp_seen++;
            last_rdata = bus.o_rdata;
        end
        if (int'(bus.o_outstanding) > peak_out) peak_out = int'(bus.o_outstanding);
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    endtask

    task automatic req(input logic ren, input logic wen,
                       input logic [31:0] addr, input logic [3:0] mask,
                       input logic [31:0] wdata);
        acc_flag = 1'b0;
        for (int k = 0; k < 20 && !acc_flag; k++) step(ren, wen, addr, mask, wdata);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.i_ren = 1'b0;
        bus.i_wen = 1'b0;
        rst_n  = 1'b0;
        in_rst = 1'b1;
        q.delete();
        #1;
        chk("rst_async_out", 32'(bus.o_outstanding), 32'd0);
        chk("rst_async_valid", 32'(bus.o_valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            edge_n++;
            @(negedge clk);
            chk("rst_ready", 32'(bus.o_ready), 32'd0);
            chk("rst_valid", 32'(bus.o_valid), 32'd0);
            chk("rst_rdata", bus.o_rdata, 32'd0);
            chk("rst_out", 32'(bus.o_outstanding), 32'd0);
        end
        rst_n    = 1'b1;
        in_rst   = 1'b0;
        rel_edge = edge_n + 1;
        last_acc = -100;
    endtask

    initial begin
        int          base;
        int          widx;
        logic [31:0] a;
        rst_n       = 1'b0;
        bus.i_ren   = 1'b0;
        bus.i_wen   = 1'b0;
        bus.i_addr  = 32'd0;
        bus.i_mask  = 4'd0;
        bus.i_wdata = 32'd0;
        edge_n   = 0;
        rel_edge = 1000000;
        last_acc = -100;
        n_chk    = 0;
        n_fail   = 0;
        rsp_seen = 0;
        peak_out = 0;
        last_rdata = 32'd0;

        do_reset();
        idle(1);

        req(1'b0, 1'b1, 32'h0, 4'hF, 32'd1);
        req(1'b0, 1'b1, 32'h4, 4'hF, 32'd2);
        req(1'b0, 1'b1, 32'h8, 4'hF, 32'd3);
        req(1'b0, 1'b1, 32'h14, 4'hF, 32'hDEADBEEF);
        idle(2);

        req(1'b1, 1'b0, 32'h14, 4'h0, 32'd0);
        idle(LAT + 1);
        chk("single_read", last_rdata, 32'hDEADBEEF);

        peak_out = 0;
        base = rsp_seen;
        req(1'b1, 1'b0, 32'h0, 4'h0, 32'd0);
        req(1'b1, 1'b0, 32'h4, 4'h0, 32'd0);
        req(1'b1, 1'b0, 32'h8, 4'h0, 32'd0);
        idle(LAT + 2);
        chk("b2b_count", 32'(rsp_seen - base), 32'd3);
        chk("b2b_last", last_rdata, 32'd3);
        chk("b2b_peak", 32'(peak_out), 32'd2);

        req(1'b0, 1'b1, 32'h8, 4'hF, 32'hAABBCCDD);
        req(1'b0, 1'b1, 32'h8, 4'b0101, 32'h11223344);
        req(1'b1, 1'b0, 32'h8, 4'h0, 32'd0);
        idle(LAT + 1);
        chk("masked_write", last_rdata, 32'hAA22CC44);

        base = rsp_seen;
        req(1'b1, 1'b0, 32'h1000, 4'h0, 32'd0);
        step(1'b1, 1'b0, 32'h14, 4'h0, 32'd0);
        idle(LAT + 1);
        chk("wrap_read", last_rdata, 32'd1);
        chk("ignored_count", 32'(rsp_seen - base), 32'd1);

        req(1'b1, 1'b1, 32'h4, 4'hF, 32'h55667788);
        idle(LAT + 1);
        chk("rw_same_edge", last_rdata, 32'd2);

        base = rsp_seen;
        req(1'b1, 1'b0, 32'h14, 4'h0, 32'd0);
        idle(1);
        do_reset();
        idle(LAT + 3);
        chk("reset_drop", 32'(rsp_seen - base), 32'd0);

        for (int i = 0; i < 16; i++) begin
            req(1'b0, 1'b1, 32'(i * 4), 4'hF, $urandom);
        end
        for (int i = 0; i < 300; i++) begin
            widx = $urandom_range(0, 15);
            a = 32'($urandom_range(0, 3) * 4096 + widx * 4 + $urandom_range(0, 3));
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                 a, 4'($urandom_range(0, 15)), $urandom);
        end
        idle(LAT + 2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
